// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct codes,
// aluop and datapath mux selects, plus the DECODE dispatch helper.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11,
        StSpare   = 4'd12
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } aluop_e;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAluResult = 2'b00;
    localparam logic [1:0] PcAluOut    = 2'b01;
    localparam logic [1:0] PcJump      = 2'b10;

    // StFetch as a DECODE target means the opcode is illegal.
    function automatic state_e decode_target(input logic [5:0] op, input logic bne_en);
        case (op)
            OpLw, OpSw: return StMemAdr;
            OpRtype:    return StExecute;
            OpBeq:      return StBranch;
            OpBne:      return bne_en ? StBranch : StFetch;
            OpAddi:     return StAddiEx;
            OpJ:        return StJump;
            default:    return StFetch;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps aluop and the R-type funct field onto the ALU control code.
module mc_aludec
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3
) (
    input  aluop_e               aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [2:0] ctl;

    always_comb begin
        ctl = 3'b000;
        case (aluop)
            AluOpAdd: ctl = 3'b010;
            AluOpSub: ctl = 3'b110;
            AluOpFunct: begin
                case (funct)
                    FnAdd:   ctl = 3'b010;
                    FnSub:   ctl = 3'b110;
                    FnAnd:   ctl = 3'b000;
                    FnOr:    ctl = 3'b001;
                    FnSlt:   ctl = 3'b111;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(ctl);

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle MIPS datapath with memory-ready stalls.
// Define MULTICYCLE_BNE_EN to add bne (opcode 000101) support.
module multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned STATE_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal_op,
    output logic                 instr_done,
    output logic [STATE_W-1:0]   state
);

    state_e state_q, state_d;
    aluop_e aluop;
    logic   pcwrite;
    logic   branch;
    logic   branch_taken;
    state_e decode_next;

`ifdef MULTICYCLE_BNE_EN
    localparam logic BneEn = 1'b1;
    logic is_bne_q;
    assign branch_taken = is_bne_q ? ~zero : zero;
`else
    localparam logic BneEn = 1'b0;
    assign branch_taken = zero;
`endif

    assign decode_next = decode_target(opcode, BneEn);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StFetch:   state_d = mem_ready ? StDecode : StFetch;
            StDecode:  state_d = decode_next;
            StMemAdr:  state_d = (opcode == OpSw) ? StMemWr : StMemRd;
            StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
            StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StFetch;
`ifdef MULTICYCLE_BNE_EN
            is_bne_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef MULTICYCLE_BNE_EN
            if (state_q == StDecode) begin
                is_bne_q <= (opcode == OpBne);
            end
`endif
        end
    end

    always_comb begin
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SrcBReg;
        pcsrc      = PcAluResult;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        aluop      = AluOpAdd;
        illegal_op = 1'b0;
        instr_done = 1'b0;
        unique case (state_q)
            StFetch: begin
                memread = 1'b1;
                alusrcb = SrcBFour;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            StDecode: begin
                alusrcb    = SrcBImmSh;
                illegal_op = (decode_next == StFetch);
            end
            StMemAdr, StAddiEx: begin
                alusrca = 1'b1;
                alusrcb = SrcBImm;
            end
            StMemRd: begin
                iord    = 1'b1;
                memread = 1'b1;
            end
            StMemWb: begin
                regwrite   = 1'b1;
                memtoreg   = 1'b1;
                instr_done = 1'b1;
            end
            StMemWr: begin
                iord       = 1'b1;
                memwrite   = 1'b1;
                instr_done = mem_ready;
            end
            StExecute: begin
                alusrca = 1'b1;
                aluop   = AluOpFunct;
            end
            StAluWb: begin
                regwrite   = 1'b1;
                regdst     = 1'b1;
                instr_done = 1'b1;
            end
            StBranch: begin
                alusrca    = 1'b1;
                aluop      = AluOpSub;
                branch     = 1'b1;
                pcsrc      = PcAluOut;
                instr_done = 1'b1;
            end
            StAddiWb: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
            end
            StJump: begin
                pcsrc      = PcJump;
                pcwrite    = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase

        pcen = pcwrite | (branch & branch_taken);

        // Reset abandons the instruction at once, so nothing may strobe while it is low.
        if (!reset_n) begin
            iord       = 1'b0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regdst     = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b0;
            alusrca    = 1'b0;
            alusrcb    = SrcBReg;
            pcsrc      = PcAluResult;
            pcen       = 1'b0;
            illegal_op = 1'b0;
            instr_done = 1'b0;
        end
    end

    mc_aludec #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_aludec (
        .aluop     (aluop),
        .funct     (funct),
        .alucontrol(alucontrol)
    );

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  opcode = 6'b0;
    logic [5:0]  funct = 6'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b1;
    logic        iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0]  alusrcb, pcsrc;
    logic        pcen, illegal_op, instr_done;
    logic [2:0]  alucontrol;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_controller #(
        .ALUCTRL_W(3),
        .STATE_W  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opcode    (opcode),
        .funct     (funct),
        .zero      (zero),
        .mem_ready (mem_ready),
        .iord      (iord),
        .memread   (memread),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .pcsrc     (pcsrc),
        .pcen      (pcen),
        .alucontrol(alucontrol),
        .illegal_op(illegal_op),
        .instr_done(instr_done),
        .state     (state)
    );

    localparam logic [5:0] ORtype = 6'b000000;
    localparam logic [5:0] OLw    = 6'b100011;
    localparam logic [5:0] OSw    = 6'b101011;
    localparam logic [5:0] OBeq   = 6'b000100;
    localparam logic [5:0] OBne   = 6'b000101;
    localparam logic [5:0] OAddi  = 6'b001000;
    localparam logic [5:0] OJ     = 6'b000010;
    localparam logic [5:0] OBad   = 6'b111111;

    // {iord,memread,memwrite,irwrite}_{regdst,memtoreg,regwrite,alusrca}_alusrcb_pcsrc_
    // {pcen,illegal_op,instr_done}
    localparam logic [14:0] VZero       = 15'b0000_0000_00_00_000;
    localparam logic [14:0] VFetch      = 15'b0101_0000_01_00_100;
    localparam logic [14:0] VFetchStall = 15'b0100_0000_01_00_000;
    localparam logic [14:0] VDecode     = 15'b0000_0000_11_00_000;
    localparam logic [14:0] VDecodeIll  = 15'b0000_0000_11_00_010;
    localparam logic [14:0] VMemAdr     = 15'b0000_0001_10_00_000;
    localparam logic [14:0] VMemRd      = 15'b1100_0000_00_00_000;
    localparam logic [14:0] VMemWb      = 15'b0000_0110_00_00_001;
    localparam logic [14:0] VMemWrStall = 15'b1010_0000_00_00_000;
    localparam logic [14:0] VMemWr      = 15'b1010_0000_00_00_001;
    localparam logic [14:0] VExec       = 15'b0000_0001_00_00_000;
    localparam logic [14:0] VAluWb      = 15'b0000_1010_00_00_001;
    localparam logic [14:0] VBrTaken    = 15'b0000_0001_00_01_101;
    localparam logic [14:0] VBrNot      = 15'b0000_0001_00_01_001;
    localparam logic [14:0] VAddiEx     = 15'b0000_0001_10_00_000;
    localparam logic [14:0] VAddiWb     = 15'b0000_0010_00_00_001;
    localparam logic [14:0] VJump       = 15'b0000_0000_00_10_101;

    typedef struct {
        string      name;
        logic [3:0] st;
        logic [14:0] vec;
        logic       chk_alu;
        logic [2:0] alu;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic step(input string name, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic z, input logic rdy,
                        input logic [3:0] st, input logic [14:0] v, input logic ca,
                        input logic [2:0] alu);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rst;
        opcode    = op;
        funct     = fn;
        zero      = z;
        mem_ready = rdy;
        e.name = name;
        e.st = st;
        e.vec = v;
        e.chk_alu = ca;
        e.alu = alu;
        sb.push_back(e);
    endtask

    // Monitor: one vector is presented per cycle, checked mid-cycle.
    initial begin
        exp_t       e;
        logic [14:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                       alusrcb, pcsrc, pcen, illegal_op, instr_done};
                vectors++;
                if (state !== e.st || act !== e.vec || (e.chk_alu && alucontrol !== e.alu))
                begin
                    miscompares++;
                    $display("FAIL %s: got state=%0d ctl=%b alu=%b, want state=%0d ctl=%b alu=%b",
                             e.name, state, act, alucontrol, e.st, e.vec, e.alu);
                end
            end
        end
    end

    initial begin
        repeat (3) step("reset_hold", 0, OLw, 6'h00, 0, 1, 4'd0, VZero, 0, 3'b000);

        step("lw_fetch",  1, OLw, 6'h00, 0, 1, 4'd0, VFetch,  1, 3'b010);
        step("lw_decode", 1, OLw, 6'h00, 0, 1, 4'd1, VDecode, 1, 3'b010);
        step("lw_memadr", 1, OLw, 6'h00, 0, 1, 4'd2, VMemAdr, 1, 3'b010);
        step("lw_memrd",  1, OLw, 6'h00, 0, 1, 4'd3, VMemRd,  0, 3'b000);
        step("lw_memwb",  1, OLw, 6'h00, 0, 1, 4'd4, VMemWb,  0, 3'b000);

        repeat (2) step("sub_fetch_stall", 1, ORtype, 6'b100010, 0, 0, 4'd0, VFetchStall, 1,
                        3'b010);
        step("sub_fetch",   1, ORtype, 6'b100010, 0, 1, 4'd0, VFetch,  1, 3'b010);
        step("sub_decode",  1, ORtype, 6'b100010, 0, 1, 4'd1, VDecode, 1, 3'b010);
        step("sub_execute", 1, ORtype, 6'b100010, 0, 1, 4'd6, VExec,   1, 3'b110);
        step("sub_aluwb",   1, ORtype, 6'b100010, 0, 1, 4'd7, VAluWb,  0, 3'b000);

        step("or_fetch",   1, ORtype, 6'b100101, 0, 1, 4'd0, VFetch,  1, 3'b010);
        step("or_decode",  1, ORtype, 6'b100101, 0, 1, 4'd1, VDecode, 1, 3'b010);
        step("or_execute", 1, ORtype, 6'b100101, 0, 1, 4'd6, VExec,   1, 3'b001);
        step("or_aluwb",   1, ORtype, 6'b100101, 0, 1, 4'd7, VAluWb,  0, 3'b000);

        step("slt_fetch",   1, ORtype, 6'b101010, 0, 1, 4'd0, VFetch,  1, 3'b010);
        step("slt_decode",  1, ORtype, 6'b101010, 0, 1, 4'd1, VDecode, 1, 3'b010);
        step("slt_execute", 1, ORtype, 6'b101010, 0, 1, 4'd6, VExec,   1, 3'b111);
        step("slt_aluwb",   1, ORtype, 6'b101010, 0, 1, 4'd7, VAluWb,  0, 3'b000);

        step("badfn_fetch",   1, ORtype, 6'b111111, 0, 1, 4'd0, VFetch,  1, 3'b010);
        step("badfn_decode",  1, ORtype, 6'b111111, 0, 1, 4'd1, VDecode, 1, 3'b010);
        step("badfn_execute", 1, ORtype, 6'b111111, 0, 1, 4'd6, VExec,   1, 3'b000);
        step("badfn_aluwb",   1, ORtype, 6'b111111, 0, 1, 4'd7, VAluWb,  0, 3'b000);

        step("beq_t_fetch",  1, OBeq, 6'h00, 1, 1, 4'd0, VFetch,   1, 3'b010);
        step("beq_t_decode", 1, OBeq, 6'h00, 1, 1, 4'd1, VDecode,  1, 3'b010);
        step("beq_t_branch", 1, OBeq, 6'h00, 1, 1, 4'd8, VBrTaken, 1, 3'b110);

        step("beq_n_fetch",  1, OBeq, 6'h00, 0, 1, 4'd0, VFetch,  1, 3'b010);
        step("beq_n_decode", 1, OBeq, 6'h00, 0, 1, 4'd1, VDecode, 1, 3'b010);
        step("beq_n_branch", 1, OBeq, 6'h00, 0, 1, 4'd8, VBrNot,  1, 3'b110);

        step("bne_fetch", 1, OBne, 6'h00, 0, 1, 4'd0, VFetch, 1, 3'b010);
`ifdef MULTICYCLE_BNE_EN
        step("bne_decode", 1, OBne, 6'h00, 0, 1, 4'd1, VDecode,  1, 3'b010);
        step("bne_branch", 1, OBne, 6'h00, 0, 1, 4'd8, VBrTaken, 1, 3'b110);
`else
        step("bne_illegal", 1, OBne, 6'h00, 0, 1, 4'd1, VDecodeIll, 1, 3'b010);
`endif

        step("ill_fetch",  1, OBad, 6'h00, 0, 1, 4'd0, VFetch,     1, 3'b010);
        step("ill_decode", 1, OBad, 6'h00, 0, 1, 4'd1, VDecodeIll, 1, 3'b010);

        step("addi_fetch",  1, OAddi, 6'h00, 0, 1, 4'd0,  VFetch,  1, 3'b010);
        step("addi_decode", 1, OAddi, 6'h00, 0, 1, 4'd1,  VDecode, 1, 3'b010);
        step("addi_ex",     1, OAddi, 6'h00, 0, 1, 4'd9,  VAddiEx, 1, 3'b010);
        step("addi_wb",     1, OAddi, 6'h00, 0, 1, 4'd10, VAddiWb, 0, 3'b000);

        step("j_fetch",  1, OJ, 6'h00, 0, 1, 4'd0,  VFetch,  1, 3'b010);
        step("j_decode", 1, OJ, 6'h00, 0, 1, 4'd1,  VDecode, 1, 3'b010);
        step("j_jump",   1, OJ, 6'h00, 0, 1, 4'd11, VJump,   0, 3'b000);

        step("sw_fetch",       1, OSw, 6'h00, 0, 1, 4'd0, VFetch,      1, 3'b010);
        step("sw_decode",      1, OSw, 6'h00, 0, 1, 4'd1, VDecode,     1, 3'b010);
        step("sw_memadr",      1, OSw, 6'h00, 0, 1, 4'd2, VMemAdr,     1, 3'b010);
        step("sw_memwr_stall", 1, OSw, 6'h00, 0, 0, 4'd5, VMemWrStall, 0, 3'b000);
        step("sw_memwr",       1, OSw, 6'h00, 0, 1, 4'd5, VMemWr,      0, 3'b000);

        step("swr_fetch",       1, OSw, 6'h00, 0, 1, 4'd0, VFetch,      1, 3'b010);
        step("swr_decode",      1, OSw, 6'h00, 0, 1, 4'd1, VDecode,     1, 3'b010);
        step("swr_memadr",      1, OSw, 6'h00, 0, 1, 4'd2, VMemAdr,     1, 3'b010);
        step("swr_memwr_stall", 1, OSw, 6'h00, 0, 0, 4'd5, VMemWrStall, 0, 3'b000);
        step("swr_reset_drop",  0, OSw, 6'h00, 0, 0, 4'd5, VZero,       0, 3'b000);
        step("swr_refetch",     1, OLw, 6'h00, 0, 1, 4'd0, VFetch,      1, 3'b010);

        repeat (3) @(posedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS datapath, the successor to the single-cycle controller. A Moore FSM sequences each instruction over 3–5 cycles. It drives shared-memory, register-file, ALU-mux and PC-enable strobes from the opcode and funct fields of the latched instruction register. It also adds a memory-ready handshake so the datapath can stall on slow memory, and it flags illegal opcodes.

## Interface
Parameters:
- `ALUCTRL_W`, default 3: width of `alucontrol`.
- `STATE_W`, default 4: width of the state register and the `state` debug port.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `opcode`, input, 6: instr[31:26] from the instruction register.
- `funct`, input, 6: instr[5:0], used for R-type only.
- `zero`, input, 1: ALU result is zero.
- `mem_ready`, input, 1: memory has completed the current access this cycle.
- `iord`, output, 1: memory address source; 0 = PC, 1 = ALUOut.
- `memread`, output, 1: memory read strobe.
- `memwrite`, output, 1: memory write strobe.
- `irwrite`, output, 1: load the instruction register.
- `regdst`, output, 1: write-register select; 1 = rd, 0 = rt.
- `memtoreg`, output, 1: write-data select; 1 = data register, 0 = ALUOut.
- `regwrite`, output, 1: register-file write enable.
- `alusrca`, output, 1: ALU A source; 0 = PC, 1 = register A.
- `alusrcb`, output, 2: ALU B source; 00 = B, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc`, output, 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen`, output, 1: PC write enable, equal to `pcwrite | (branch & branch_taken)`.
- `alucontrol`, output, `ALUCTRL_W`: ALU operation.
- `illegal_op`, output, 1: one-cycle pulse on an unknown opcode.
- `instr_done`, output, 1: one-cycle pulse in the last state of each instruction.
- `state`, output, `STATE_W`: current state, for debug.

## Operation
States and transitions:
- FETCH → DECODE. Stays in FETCH while `mem_ready` = 0.
- DECODE → next state by opcode:
  - lw/sw (100011/101011) → MEMADR.
  - R-type (000000) → EXECUTE.
  - beq (000100) → BRANCH.
  - addi (001000) → ADDIEX.
  - j (000010) → JUMP.
  - Any other opcode → FETCH with `illegal_op` = 1.
- MEMADR → MEMRD for lw, MEMWR for sw.
- MEMRD → MEMWB. Stays in MEMRD while `mem_ready` = 0.
- MEMWR → FETCH. Stays in MEMWR while `mem_ready` = 0.
- EXECUTE → ALUWB.
- ADDIEX → ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.

Outputs per state (any strobe not listed is 0):
- FETCH: `memread`=1, `alusrcb`=01, aluop=add, `pcsrc`=00. `irwrite` and `pcwrite` equal `mem_ready`.
- DECODE: `alusrcb`=11, aluop=add.
- MEMADR: `alusrca`=1, `alusrcb`=10, aluop=add.
- MEMRD: `iord`=1, `memread`=1.
- MEMWB: `regwrite`=1, `memtoreg`=1, `regdst`=0.
- MEMWR: `iord`=1, `memwrite`=1.
- EXECUTE: `alusrca`=1, `alusrcb`=00, aluop=funct.
- ALUWB: `regwrite`=1, `regdst`=1, `memtoreg`=0.
- BRANCH: `alusrca`=1, `alusrcb`=00, aluop=sub, branch=1, `pcsrc`=01. Branch is taken when `branch_taken` = `zero`.
- ADDIEX: `alusrca`=1, `alusrcb`=10, aluop=add.
- ADDIWB: `regwrite`=1, `regdst`=0.
- JUMP: `pcsrc`=10, `pcwrite`=1.

`alucontrol` (zero-extended to `ALUCTRL_W`):
- aluop=add → 010; aluop=sub → 110.
- aluop=funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111. Any other funct → 000. An unknown funct does not raise `illegal_op`.

## Timing
- Reset: with `reset_n` low at a rising edge, the state becomes FETCH. While `reset_n` is low, every output strobe, `pcen`, `illegal_op` and `instr_done` is forced to 0. After reset, `state` reads the FETCH encoding, 0.
- Reset mid-instruction: the instruction is abandoned with no further writes. After reset releases, fetching restarts on the next edge.
- Latency with `mem_ready` held at 1:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
  - Each cycle of `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- While stalled: `memread`/`memwrite` and `iord` stay asserted, and `irwrite`, `pcwrite` and `pcen` are 0.
- `mem_ready` is ignored in all other states.
- Outputs are combinational from the registered state and current inputs; there is no output register.

## Configuration
- `MULTICYCLE_BNE_EN` defined: opcode 000101 (bne) decodes to BRANCH. A latched `is_bne` bit, set in DECODE, makes `branch_taken` = `~zero` for that instruction.
- `MULTICYCLE_BNE_EN` undefined: 000101 is illegal.

## Structure
- Shared package `mips_mc_pkg` holds:
  - the state encodings (FETCH=0 … JUMP=11, plus a spare);
  - the opcode and funct constants;
  - the aluop encoding (add=00, sub=01, funct=10);
  - the `alusrcb` and `pcsrc` encodings.
- Sub-module `mc_aludec`: combinational aluop/funct → `alucontrol` decoder. The FSM and output decode stay in `multicycle_controller`.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles → all strobes 0. Release → `state`=FETCH, with `memread`=1 and `irwrite`=1 while `mem_ready`=1.
- **lw:** opcode 100011, `mem_ready`=1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `regwrite`=1 and `memtoreg`=1 in cycle 5; `instr_done` pulses once.
- **R-type stall:** R-type sub (funct 100010) with `mem_ready`=0 for 2 FETCH cycles → 6 cycles total, `alucontrol`=110 in EXECUTE, `irwrite` asserted only in the ready cycle.
- **beq:** `zero`=1 → `pcen`=1, `pcsrc`=01 in BRANCH. With `zero`=0 → `pcen`=0. With BNE_EN defined, bne with `zero`=0 → `pcen`=1.
- **Illegal opcode:** opcode 111111 → `illegal_op` pulses in DECODE, next state FETCH, `regwrite`/`memwrite` never asserted.
- **Mid-instruction reset:** assert `reset_n`=0 during MEMWR → the next state is FETCH and `memwrite` drops immediately.
